ffc_frame_packer: RTL

FFC_FRAME_PACKER -- requirements
Module: ffc_frame_packer

---
 rtl/ffc_pkg.sv | 31 +++
 rtl/ffc_frame_chan.sv | 86 ++++++++
 rtl/ffc_frame_packer.sv | 115 +++++++++++
 3 files changed

// File: rtl/ffc_pkg.sv
// Shared types and sizing helpers for the FFT frame packer: channel/top state
// encodings and the NFFT-derived widths used by the packer and its channels.
package ffc_pkg;

    localparam int NFFT_DEFAULT = 256;
    localparam int NFFT_MIN     = 16;
    localparam int NFFT_MAX     = 8192;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_LOAD,
        CH_PAD,
        CH_DONE
    } chan_state_t;

    typedef enum logic {
        TOP_IDLE,
        TOP_RUN
    } top_state_t;

    // Width of an N1/N2 length field: must be able to hold NFFT itself.
    function automatic int len_width(input int nfft);
        return $clog2(nfft) + 1;
    endfunction

    // Width of the per-channel beat index 0..NFFT-1.
    function automatic int idx_width(input int nfft);
        return $clog2(nfft);
    endfunction

endpackage

// File: rtl/ffc_frame_chan.sv
// One packer channel: forwards eff_n input samples, then zero-pads the frame
// out to NFFT beats, with tlast on the final beat.
module ffc_frame_chan
    import ffc_pkg::*;
#(
    parameter int NFFT   = NFFT_DEFAULT,
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(NFFT) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              load,
    input  logic [LEN_W-1:0]  eff_n,
    input  logic [DATA_W-1:0] func_tdata,
    input  logic              func_tvalid,
    output logic              func_tready,
    output logic [DATA_W-1:0] fft_tdata,
    output logic              fft_tvalid,
    output logic              fft_tlast,
    input  logic              fft_tready,
    output logic              done,
    output chan_state_t       state
);

    localparam int IDX_W = idx_width(NFFT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

    chan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [LEN_W-1:0] n_q;
    logic             beat;
    logic             at_last;
    logic             at_fill_end;

    assign beat        = fft_tvalid && fft_tready;
    assign at_last     = (idx_q == LAST_IDX);
    assign at_fill_end = (LEN_W'(idx_q) == n_q - LEN_W'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= CH_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                idx_q <= '0;
                n_q   <= eff_n;
            end else if (beat) begin
                idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // The final-beat exit wins over the fill-end exit so a full frame skips PAD.
    always_comb begin
        state_d     = state_q;
        func_tready = 1'b0;
        fft_tdata   = '0;
        fft_tvalid  = 1'b0;
        case (state_q)
            CH_IDLE, CH_DONE: begin
                if (load) state_d = (eff_n == '0) ? CH_PAD : CH_LOAD;
            end
            CH_LOAD: begin
                fft_tdata   = func_tdata;
                fft_tvalid  = func_tvalid;
                func_tready = fft_tready;
                if (beat) begin
                    if (at_last)          state_d = CH_DONE;
                    else if (at_fill_end) state_d = CH_PAD;
                end
            end
            CH_PAD: begin
                fft_tvalid = 1'b1;
                if (beat && at_last) state_d = CH_DONE;
            end
            default: state_d = CH_IDLE;
        endcase
        fft_tlast = fft_tvalid && at_last;
    end

    assign done  = (state_q == CH_DONE);
    assign state = state_q;

endmodule

// File: rtl/ffc_frame_packer.sv
// Packs two sample streams into NFFT-long zero-padded frames on a start pulse.
// Optional FFC_LIN_CHECK_EN rejects frame pairs whose linear correlation would alias.
module ffc_frame_packer
    import ffc_pkg::*;
#(
    parameter int NFFT   = NFFT_DEFAULT,
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(NFFT) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [LEN_W-1:0]  N1,
    input  logic [LEN_W-1:0]  N2,
    input  logic              start,
    output logic              idle,
    output logic              len_err,
    input  logic [DATA_W-1:0] func_1_tdata,
    input  logic              func_1_tvalid,
    output logic              func_1_tready,
    input  logic [DATA_W-1:0] func_2_tdata,
    input  logic              func_2_tvalid,
    output logic              func_2_tready,
    output logic [DATA_W-1:0] fft_1_tdata,
    output logic              fft_1_tvalid,
    output logic              fft_1_tlast,
    input  logic              fft_1_tready,
    output logic [DATA_W-1:0] fft_2_tdata,
    output logic              fft_2_tvalid,
    output logic              fft_2_tlast,
    input  logic              fft_2_tready,
    output top_state_t        dbg_state
);

    // Handshake: a beat moves on any rising aclk where tvalid && tready; a source
    // holding tvalid keeps tdata/tlast stable until that beat.
    localparam logic [LEN_W-1:0] NFFT_L = LEN_W'(NFFT);

    top_state_t       state_q, state_d;
    logic [LEN_W-1:0] eff_1, eff_2;
    logic             over_len;
    logic             aliasing;
    logic             start_seen;
    logic             accept;
    logic             done_1, done_2;
    chan_state_t      chan_1_state, chan_2_state;

    assign eff_1    = (N1 > NFFT_L) ? NFFT_L : N1;
    assign eff_2    = (N2 > NFFT_L) ? NFFT_L : N2;
    assign over_len = (N1 > NFFT_L) || (N2 > NFFT_L);

`ifdef FFC_LIN_CHECK_EN
    // eff_1 + eff_2 - 1 > NFFT, rearranged so an empty pair cannot underflow.
    assign aliasing = ({1'b0, eff_1} + {1'b0, eff_2}) > ((LEN_W + 1)'(NFFT) + (LEN_W + 1)'(1));
`else
    assign aliasing = 1'b0;
`endif

    assign start_seen = start && (state_q == TOP_IDLE);
    assign accept     = start_seen && !aliasing;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= TOP_IDLE;
            len_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_seen) len_err <= over_len || aliasing;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TOP_IDLE: if (accept) state_d = TOP_RUN;
            TOP_RUN:  if (done_1 && done_2) state_d = TOP_IDLE;
            default:  state_d = TOP_IDLE;
        endcase
    end

    assign idle      = (state_q == TOP_IDLE);
    assign dbg_state = state_q;

    ffc_frame_chan #(.NFFT(NFFT), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_chan_1 (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .load        (accept),
        .eff_n       (eff_1),
        .func_tdata  (func_1_tdata),
        .func_tvalid (func_1_tvalid),
        .func_tready (func_1_tready),
        .fft_tdata   (fft_1_tdata),
        .fft_tvalid  (fft_1_tvalid),
        .fft_tlast   (fft_1_tlast),
        .fft_tready  (fft_1_tready),
        .done        (done_1),
        .state       (chan_1_state)
    );

    ffc_frame_chan #(.NFFT(NFFT), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_chan_2 (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .load        (accept),
        .eff_n       (eff_2),
        .func_tdata  (func_2_tdata),
        .func_tvalid (func_2_tvalid),
        .func_tready (func_2_tready),
        .fft_tdata   (fft_2_tdata),
        .fft_tvalid  (fft_2_tvalid),
        .fft_tlast   (fft_2_tlast),
        .fft_tready  (fft_2_tready),
        .done        (done_2),
        .state       (chan_2_state)
    );

endmodule
